banked_burst_ram: RTL
=====================

Name: banked_burst_ram

Overview:
- Parametrised successor to the fixed four-bank RAM: 2**BANK_BITS synchronous banks behind a single command port.
- Separate read and write data buses replace the shared tri-state bus.
- Supports multi-beat bursts with an internal auto-incrementing address that crosses bank boundaries, and a valid/ready handshake on write data.
- Sits between a bus master (CPU/DMA) and on-chip storage.

Parameters:
ADDR_WIDTH, 8, word address width; total depth 2**ADDR_WIDTH words
DATA_WIDTH, 8, word width in bits
BANK_BITS, 2, number of address MSBs used as bank select; 2**BANK_BITS banks, each 2**(ADDR_WIDTH-BANK_BITS) deep; legal range 1..ADDR_WIDTH-1
LEN_WIDTH, 4, burst length field width; a burst is cmd_len+1 beats (1..2**LEN_WIDTH)

Ports:
clk  input  1  clock; all logic on rising edge
rstn  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_we  input  1  1 = write burst, 0 = read burst
cmd_addr  input  ADDR_WIDTH  start word address
cmd_len  input  LEN_WIDTH  beats minus one
wdata  input  DATA_WIDTH  write beat data
wdata_valid  input  1  write beat offered
wdata_ready  output  1  write beat accepted when wdata_valid && wdata_ready
rdata  output  DATA_WIDTH  read beat data
rdata_valid  output  1  rdata holds a read beat this cycle
bank_sel  output  2**BANK_BITS  one-hot bank accessed this cycle; 0 when idle/stalled
busy  output  1  burst in progress

Behaviour:
- Reset (rstn low at edge): state IDLE, cmd_ready=1 from next cycle, wdata_ready=0, rdata_valid=0, rdata=0, bank_sel=0, busy=0, internal address/count cleared. Memory contents are not cleared.
- Reset mid-burst: remaining beats are dropped, and a pending read beat is not presented.
- Mapping: bank = addr[ADDR_WIDTH-1 -: BANK_BITS]; row = remaining LSBs. At most one bank is enabled per cycle.
- FSM states: IDLE, WR, RD.
- IDLE: cmd_ready=1, busy=0.
  - On accept: latch addr into cur_addr and cmd_len into remaining.
  - Go to WR if cmd_we, else RD.
- WR: cmd_ready=0, wdata_ready=1, busy=1.
  - On each beat handshake: write wdata to cur_addr, cur_addr+1, remaining-1.
  - No handshake: no write and bank_sel=0 (stall of any length allowed).
  - Beat with remaining==0 is the last; next state is IDLE.
- RD: cmd_ready=0, busy=1.
  - Issues one read per cycle, unconditionally; no read backpressure.
  - Beat issued at cycle t appears on rdata with rdata_valid=1 at t+1, so read latency is 1.
  - After issuing the beat with remaining==0, go to IDLE. The final rdata_valid pulse occurs in the first IDLE cycle.
  - A new command may be accepted in that same cycle.
- A burst of N beats occupies exactly N cycles in RD.
- rdata holds its last value when rdata_valid=0; it is not zeroed.
- Address arithmetic is modulo 2**ADDR_WIDTH. Increment crosses banks transparently, and address 2**ADDR_WIDTH-1 wraps to 0.
- cmd_valid while cmd_ready=0 is ignored; the master must hold it. wdata_valid outside WR is ignored.
- Write-then-read to the same address in back-to-back bursts returns the new data.
- cmd_len field is only sampled at acceptance; later changes have no effect.

Test Plan:
- Single beat: write addr 0x05 data 0xA5 len 0, then read addr 0x05 len 0 -> rdata=0xA5 with rdata_valid exactly one cycle after RD issue; bank_sel=4'b0001 both accesses.
- Bank-crossing burst: write addr 0x3E len 3, data 0x11,0x22,0x33,0x44 -> bank_sel 0001,0001,0010,0010. Read back the same range -> 0x11..0x44 on 4 consecutive rdata_valid cycles.
- Wrap-around: write addr 0xFF len 1, data 0xDE,0xAD -> read 0xFF returns 0xDE and read 0x00 returns 0xAD; bank_sel 1000 then 0001.
- Write stall: wdata_valid low for 3 cycles mid-burst -> no write, bank_sel=0, busy stays 1, and data lands at the correct consecutive addresses.
- Reset mid-read: assert rstn=0 during beat 2 of an 8-beat read -> next cycle rdata_valid=0, busy=0, rdata=0. Earlier-written data is still readable afterwards.
- Back-to-back: read len 0 followed immediately by a new command in the IDLE cycle -> command accepted in the same cycle as rdata_valid; no beat lost or duplicated.

Source files
------------

// File: rtl/banked_burst_ram.sv
// Banked synchronous RAM with a single command port and multi-beat bursts.
// Bursts auto-increment the word address across bank boundaries, wrapping at the top of memory.
module banked_burst_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BANK_BITS  = 2,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      rdata_valid,
  output logic [(1<<BANK_BITS)-1:0] bank_sel,
  output logic                      busy
);

  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
  localparam int ROWS      = 1 << ROW_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   cur_addr_r;
  logic [LEN_WIDTH-1:0]    remaining_r;
  logic                    cmd_fire_s;
  logic                    wr_fire_s;
  logic                    rd_issue_s;
  logic                    last_beat_s;
  logic [BANK_BITS-1:0]    bank_s;
  logic [ROW_BITS-1:0]     row_s;

  logic [DATA_WIDTH-1:0]   mem_r [NUM_BANKS][ROWS];

  assign bank_s      = cur_addr_r[ADDR_WIDTH-1 -: BANK_BITS];
  assign row_s       = cur_addr_r[ROW_BITS-1:0];
  assign last_beat_s = (remaining_r == {LEN_WIDTH{1'b0}});

  // Next-state decode, handshake outputs and per-cycle bank enable
  always_comb begin
    state_nxt_s = state_r;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    busy        = 1'b0;
    cmd_fire_s  = 1'b0;
    wr_fire_s   = 1'b0;
    rd_issue_s  = 1'b0;
    bank_sel    = {NUM_BANKS{1'b0}};
    case (state_r)
      ST_IDLE: begin
        cmd_ready  = 1'b1;
        cmd_fire_s = cmd_valid;
        if (cmd_valid) begin
          state_nxt_s = cmd_we ? ST_WR : ST_RD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR: begin
        wdata_ready = 1'b1;
        busy        = 1'b1;
        wr_fire_s   = wdata_valid;
        if (wdata_valid && last_beat_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_RD: begin
        busy       = 1'b1;
        rd_issue_s = 1'b1;
        if (last_beat_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (wr_fire_s || rd_issue_s) begin
      bank_sel = NUM_BANKS'(1'b1) << bank_s;
    end else begin
      bank_sel = {NUM_BANKS{1'b0}};
    end
  end

  // State, burst address/count and registered read port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= {ADDR_WIDTH{1'b0}};
      remaining_r <= {LEN_WIDTH{1'b0}};
      rdata_valid <= 1'b0;
      rdata       <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      rdata_valid <= rd_issue_s;
      if (rd_issue_s) begin
        rdata <= mem_r[bank_s][row_s];
      end
      if (cmd_fire_s) begin
        cur_addr_r  <= cmd_addr;
        remaining_r <= cmd_len;
      end else if (wr_fire_s || rd_issue_s) begin
        // remaining underflows on the last beat, but it is reloaded before reuse
        cur_addr_r  <= cur_addr_r + ADDR_WIDTH'(1);
        remaining_r <= remaining_r - LEN_WIDTH'(1);
      end
    end
  end

  // Storage array; contents survive reset, writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (wr_fire_s && rstn) begin
      mem_r[bank_s][row_s] <= wdata;
    end
  end

endmodule
